// File: rtl/gsim_host_if.sv
// gsim_host_if -- host-side initiator for the Gauss-Seidel solver core.
//
// Collects 272 16-bit words (256 words of A, then 16 words of b) over a
// valid/ready stream, packs them into the solver's wide a/b buses, runs the
// solver through its module_en/done handshake and streams the 16 32-bit
// solution words back out over a second valid/ready stream.
//
// Optional feature macro: GSIM_TIMEOUT_EN -- when defined, a watchdog aborts
// a run that sees no capture within TIMEOUT_CYCLES cycles and raises a sticky
// o_error. When undefined, S_RUN waits forever and o_error is tied low.
//
// Ports:
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_in_valid/i_in_data  input word stream (A row-major, then b)
//   o_in_ready            high only while loading
//   o_a, o_b              packed A (4096 b) and b (256 b) to the solver
//   o_module_en, i_done   solver run handshake
//   i_x                   solver result, x[n] at bits [n*32 +: 32]
//   o_out_valid/o_out_data/i_out_ready  result word stream
//   o_busy                high outside S_LOAD
//   o_error               watchdog timeout flag (sticky)
module gsim_host_if #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_in_valid,
  input  logic [15:0]   i_in_data,
  output logic          o_in_ready,
  output logic [4095:0] o_a,
  output logic [255:0]  o_b,
  output logic          o_module_en,
  input  logic          i_done,
  input  logic [511:0]  i_x,
  output logic          o_out_valid,
  output logic [31:0]   o_out_data,
  input  logic          i_out_ready,
  output logic          o_busy,
  output logic          o_error
);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_SEND = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [8:0]    k_r;
  logic [3:0]    idx_r;
  logic          armed_r;
  logic [4095:0] a_r;
  logic [255:0]  b_r;
  logic [31:0]   res_buf_r [16];

  logic accept_s;
  logic last_word_s;
  logic capture_s;
  logic last_out_s;
  logic timeout_s;

  assign accept_s    = i_in_valid & (state_r == S_LOAD);
  assign last_word_s = (k_r == 9'd271);
  // armed_r can only be set by a low done sample, so a done level still high
  // from the previous run never triggers a capture.
  assign capture_s   = (state_r == S_RUN) & armed_r & i_done;
  assign last_out_s  = (state_r == S_SEND) & i_out_ready & (idx_r == 4'd15);

`ifdef GSIM_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_r;
  logic            error_r;

  // The cycle with wd_r = TIMEOUT_CYCLES-1 is the last S_RUN cycle allowed.
  assign timeout_s = (state_r == S_RUN) & ~capture_s &
                     (wd_r == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts S_RUN cycles, held at zero in every other state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wd_r <= '0;
    end else if (state_r == S_RUN) begin
      wd_r <= wd_r + WD_W'(1);
    end else begin
      wd_r <= '0;
    end
  end

  // Sticky timeout flag, cleared by the next accepted input word.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      error_r <= 1'b0;
    end else if (timeout_s) begin
      error_r <= 1'b1;
    end else if (accept_s) begin
      error_r <= 1'b0;
    end
  end

  assign o_error = error_r;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;

  assign timeout_s = 1'b0;
  assign o_error   = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r <= S_LOAD;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_LOAD: begin
        if (accept_s && last_word_s) begin
          state_s = S_RUN;
        end else begin
          state_s = state_r;
        end
      end
      S_RUN: begin
        if (capture_s) begin
          state_s = S_SEND;
        end else if (timeout_s) begin
          state_s = S_LOAD;
        end else begin
          state_s = state_r;
        end
      end
      S_SEND: begin
        if (last_out_s) begin
          state_s = S_LOAD;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = S_LOAD;
    endcase
  end

  // Input packing: word k lands in A for k < 256, in b otherwise.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      a_r <= 4096'd0;
      b_r <= 256'd0;
      k_r <= 9'd0;
    end else if (accept_s) begin
      if (k_r[8]) begin
        b_r[k_r[3:0] * 8'd16 +: 16] <= i_in_data;
      end else begin
        a_r[k_r[7:0] * 12'd16 +: 16] <= i_in_data;
      end
      k_r <= last_word_s ? 9'd0 : k_r + 9'd1;
    end
  end

  // armed_r: cleared while loading, set by the first low done seen in S_RUN.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      armed_r <= 1'b0;
    end else if (state_r == S_LOAD) begin
      armed_r <= 1'b0;
    end else if ((state_r == S_RUN) && !i_done) begin
      armed_r <= 1'b1;
    end
  end

  // Result capture and output word index (idx wraps 15 -> 0 on exit).
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int n = 0; n < 16; n++) begin
        res_buf_r[n] <= 32'd0;
      end
      idx_r <= 4'd0;
    end else if (capture_s) begin
      for (int n = 0; n < 16; n++) begin
        res_buf_r[n] <= i_x[n*32 +: 32];
      end
      idx_r <= 4'd0;
    end else if ((state_r == S_SEND) && i_out_ready) begin
      idx_r <= idx_r + 4'd1;
    end
  end

  // All handshake outputs decode straight from the state register.
  assign o_in_ready  = (state_r == S_LOAD);
  assign o_module_en = (state_r == S_RUN);
  assign o_out_valid = (state_r == S_SEND);
  assign o_busy      = (state_r != S_LOAD);
  assign o_out_data  = res_buf_r[idx_r];
  assign o_a         = a_r;
  assign o_b         = b_r;

endmodule

// File: tb/tb_gsim_host_if.sv
// Self-checking bench for gsim_host_if: directed stimulus, a behavioural
// model of load/run/send phases and a per-cycle compare process, plus
// hand-computed literal expectations at the interesting points.
module tb_gsim_host_if;

  localparam int TO = 20;
  localparam int P_LOAD = 0;
  localparam int P_RUN  = 1;
  localparam int P_SEND = 2;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_in_valid = 1'b0;
  logic [15:0]   i_in_data = 16'd0;
  logic          o_in_ready;
  logic [4095:0] o_a;
  logic [255:0]  o_b;
  logic          o_module_en;
  logic          i_done = 1'b0;
  logic [511:0]  i_x = 512'd0;
  logic          o_out_valid;
  logic [31:0]   o_out_data;
  logic          i_out_ready = 1'b0;
  logic          o_busy;
  logic          o_error;

  int checks = 0;
  int failures = 0;
  int hs_cnt = 0;

  gsim_host_if #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_in_valid(i_in_valid), .i_in_data(i_in_data), .o_in_ready(o_in_ready),
    .o_a(o_a), .o_b(o_b), .o_module_en(o_module_en), .i_done(i_done),
    .i_x(i_x), .o_out_valid(o_out_valid), .o_out_data(o_out_data),
    .i_out_ready(i_out_ready), .o_busy(o_busy), .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          phase = P_LOAD;
  int          cnt = 0;
  int          sidx = 0;
  int          m_wd = 0;
  logic        m_armed = 1'b0;
  logic        m_err = 1'b0;
  logic [15:0] ma [256];
  logic [15:0] mb [16];
  logic [31:0] xs [16];

  always @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      phase <= P_LOAD; cnt <= 0; sidx <= 0; m_wd <= 0;
      m_armed <= 1'b0; m_err <= 1'b0;
      for (int i = 0; i < 256; i++) ma[i] <= 16'd0;
      for (int i = 0; i < 16; i++) begin mb[i] <= 16'd0; xs[i] <= 32'd0; end
    end else begin
      case (phase)
        P_LOAD: if (i_in_valid) begin
          if (cnt < 256) ma[cnt] <= i_in_data; else mb[cnt-256] <= i_in_data;
          m_err <= 1'b0;
          if (cnt == 271) begin
            cnt <= 0; phase <= P_RUN; m_armed <= 1'b0; m_wd <= 0;
          end else cnt <= cnt + 1;
        end
        P_RUN: begin
          if (m_armed && i_done) begin
            for (int n = 0; n < 16; n++) xs[n] <= i_x[n*32 +: 32];
            sidx <= 0; phase <= P_SEND;
          end else begin
            if (!i_done) m_armed <= 1'b1;
`ifdef GSIM_TIMEOUT_EN
            m_wd <= m_wd + 1;
            if (m_wd + 1 == TO) begin phase <= P_LOAD; m_err <= 1'b1; end
`endif
          end
        end
        P_SEND: if (i_out_ready) begin
          if (sidx == 15) phase <= P_LOAD; else sidx <= sidx + 1;
        end
        default: phase <= P_LOAD;
      endcase
    end
  end

  // Handshake counter for the output stream.
  always @(posedge i_clk) begin
    if (o_out_valid && i_out_ready) hs_cnt <= hs_cnt + 1;
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge i_clk) begin
    int bad_a;
    int bad_b;
    chk("in_ready", 64'(o_in_ready), 64'(phase == P_LOAD));
    chk("module_en", 64'(o_module_en), 64'(phase == P_RUN));
    chk("out_valid", 64'(o_out_valid), 64'(phase == P_SEND));
    chk("busy", 64'(o_busy), 64'(phase != P_LOAD));
    chk("error", 64'(o_error), 64'(m_err));
    if (phase == P_SEND) chk("out_data", 64'(o_out_data), 64'(xs[sidx]));
    bad_a = -1;
    for (int w = 0; w < 256; w++) if (bad_a < 0 && o_a[w*16 +: 16] !== ma[w]) bad_a = w;
    chk("a_first_bad_word", 64'(bad_a), 64'hFFFF_FFFF_FFFF_FFFF);
    bad_b = -1;
    for (int w = 0; w < 16; w++) if (bad_b < 0 && o_b[w*16 +: 16] !== mb[w]) bad_b = w;
    chk("b_first_bad_word", 64'(bad_b), 64'hFFFF_FFFF_FFFF_FFFF);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic load_words(input logic [15:0] base, input int count);
    for (int i = 0; i < count; i++) begin
      i_in_valid = 1'b1;
      i_in_data  = base + 16'(i);
      tick();
    end
    i_in_valid = 1'b0;
  endtask

  task automatic set_x(input logic [31:0] base, input logic [31:0] mult);
    for (int n = 0; n < 16; n++) i_x[n*32 +: 32] = base + 32'(n) * mult;
  endtask

  task automatic drain(input string name, input logic [31:0] base, input logic [31:0] mult);
    i_out_ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      chk(name, 64'(o_out_data), 64'(base + 32'(n) * mult));
      tick();
    end
    chk({name, "_done_in_ready"}, 64'(o_in_ready), 64'd1);
    chk({name, "_done_out_valid"}, 64'(o_out_valid), 64'd0);
  endtask

  initial begin
    int hs_base;
    int c;

    // Reset with inputs toggling.
    for (int i = 0; i < 6; i++) begin
      tick();
      i_in_valid = ~i_in_valid; i_done = ~i_done; i_out_ready = ~i_out_ready;
      i_in_data = 16'(i + 16'h00A0);
      chk("rst_in_ready", 64'(o_in_ready), 64'd1);
      chk("rst_module_en", 64'(o_module_en), 64'd0);
      chk("rst_out_valid", 64'(o_out_valid), 64'd0);
      chk("rst_out_data", 64'(o_out_data), 64'd0);
      chk("rst_a_zero", 64'(o_a == 4096'd0), 64'd1);
      chk("rst_b_zero", 64'(o_b == 256'd0), 64'd1);
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_error", 64'(o_error), 64'd0);
    end
    i_in_valid = 1'b0; i_done = 1'b1; i_out_ready = 1'b1;
    @(negedge i_clk); #1 i_reset = 1'b0;
    tick(); tick();
    chk("post_rst_a_zero", 64'(o_a == 4096'd0), 64'd1);

    // Load packing 0x0000..0x010F.
    load_words(16'h0000, 271);
    chk("pre_last_en", 64'(o_module_en), 64'd0);
    chk("pre_last_in_ready", 64'(o_in_ready), 64'd1);
    load_words(16'h010F, 1);
    chk("last_en", 64'(o_module_en), 64'd1);
    chk("last_in_ready", 64'(o_in_ready), 64'd0);
    chk("a_lo", 64'(o_a[15:0]), 64'h0000);
    chk("a_hi", 64'(o_a[4095:4080]), 64'h00FF);
    chk("b_lo", 64'(o_b[15:0]), 64'h0100);
    chk("b_hi", 64'(o_b[255:240]), 64'h010F);

    // Stale done held high for 3 cycles, then low 2, then high.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stale_no_capture", 64'(o_out_valid), 64'd0);
    end
    i_done = 1'b0; set_x(32'h0001_0000, 32'd1);
    tick(); tick();
    chk("low_no_capture", 64'(o_out_valid), 64'd0);
    i_done = 1'b1;
    tick();
    chk("cap_valid", 64'(o_out_valid), 64'd1);
    chk("cap_en", 64'(o_module_en), 64'd0);
    set_x(32'hDEAD_0000, 32'd5);
    drain("x_stale", 32'h0001_0000, 32'd1);

    // Output backpressure at idx=7.
    load_words(16'h1000, 272);
    i_done = 1'b0; tick();
    set_x(32'd7, 32'd3); i_done = 1'b1; tick();
    hs_base = hs_cnt;
    i_out_ready = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    i_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_x7", 64'(o_out_data), 64'd28);
      tick();
    end
    i_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("bp_before_16th_in_ready", 64'(o_in_ready), 64'd0);
    tick();
    chk("bp_after_16th_in_ready", 64'(o_in_ready), 64'd1);
    chk("bp_handshakes", 64'(hs_cnt - hs_base), 64'd16);

    // Mid-run reset.
    load_words(16'h2000, 272);
    tick(); tick();
    chk("mid_en_before", 64'(o_module_en), 64'd1);
    #2 i_reset = 1'b1;
    #1;
    chk("mid_en_after", 64'(o_module_en), 64'd0);
    chk("mid_in_ready", 64'(o_in_ready), 64'd1);
    chk("mid_a_zero", 64'(o_a == 4096'd0), 64'd1);
    @(negedge i_clk); #1 i_reset = 1'b0;
    tick();
    load_words(16'h3000, 272);
    chk("reload_a_lo", 64'(o_a[15:0]), 64'h3000);
    chk("reload_b_hi", 64'(o_b[255:240]), 64'h310F);
    i_done = 1'b0; tick();
    set_x(32'h500, 32'd2); i_done = 1'b1; tick();
    drain("x_reload", 32'h500, 32'd2);

    // Watchdog (or its absence).
    load_words(16'h4000, 272);
    i_done = 1'b0;
`ifdef GSIM_TIMEOUT_EN
    c = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (c == 0 && !o_module_en) c = i;
    end
    chk("to_cycles", 64'(c), 64'd20);
    chk("to_error", 64'(o_error), 64'd1);
    chk("to_in_ready", 64'(o_in_ready), 64'd1);
    chk("to_no_output", 64'(o_out_valid), 64'd0);
    load_words(16'h0055, 1);
    chk("to_error_cleared", 64'(o_error), 64'd0);
`else
    c = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (!o_module_en) c = c + 1;
    end
    chk("no_to_en_drops", 64'(c), 64'd0);
    chk("no_to_error", 64'(o_error), 64'd0);
    set_x(32'h0BAD_0000, 32'd16); i_done = 1'b1; tick();
    drain("x_no_to", 32'h0BAD_0000, 32'd16);
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
